// File: rtl/param_deser.sv
// Receive-side width converter: packs RATIO narrow beats (beat 0 in the low bits)
// into one wide word, with optional early close via in_last and zero padding.
module param_deser #(
    parameter int OUT_W = 32,
    parameter int IN_W  = 8,
    localparam int RATIO = OUT_W / IN_W,
    localparam int CNT_W = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_beats,
    output logic             state_o
);

    // Handshake: a beat/word transfers on a rising edge where valid & ready are
    // both high; valid never waits on ready, and in_ready never looks at in_valid.

    if (IN_W == 0) begin : g_bad_in_w
        $error("param_deser: IN_W must be non-zero");
    end else if ((OUT_W % IN_W) != 0) begin : g_bad_ratio
        $error("param_deser: OUT_W must be a multiple of IN_W");
    end

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   buf_q, buf_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_beats_q, out_beats_d;
    logic [OUT_W-1:0]   merged;
    logic               accept;

    // In HOLD a new beat may only enter while the held word is being popped.
    assign in_ready  = (state_q == COLLECT) || out_ready;
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
    assign state_o   = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        accept      = in_valid && in_ready;
        merged      = buf_q;
        merged[cnt_q*IN_W +: IN_W] = in_data;

        if (state_q == HOLD && out_ready) begin
            state_d = COLLECT;
        end

        // cnt is always 0 in HOLD, so a beat accepted while popping is beat 0.
        if (accept) begin
            if (cnt_q == LAST_CNT || in_last) begin
                out_data_d  = merged;
                out_beats_d = cnt_q + 1'b1;
                cnt_d       = '0;
                buf_d       = '0;
                state_d     = HOLD;
            end else begin
                buf_d = merged;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            buf_q       <= '0;
            out_data_q  <= '0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
        end
    end

endmodule
